// File: rtl/mux_arb_pkg.sv
// Shared constants, FSM state encoding and helpers for the round-robin operand arbiter.
package mux_arb_pkg;
  localparam int IDX_W = 2;
  localparam int N_REQ = 4;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational rotating priority search: first set req bit starting at ptr+1, wrapping mod 4.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] pick,
  output logic             any
);
  always_comb begin
    logic [IDX_W-1:0] idx;
    pick = ptr;
    any  = 1'b0;
    // k = N_REQ wraps back onto ptr itself, so the current owner is searched last
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ptr + IDX_W'(k);
      if (!any && req[idx]) begin
        pick = idx;
        any  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 operand path; registered grant/select and data.
// Optional hold-time preemption enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [DATA_W-1:0] A0,
  input  logic [DATA_W-1:0] A1,
  input  logic [DATA_W-1:0] A2,
  input  logic [DATA_W-1:0] A3,
  output logic [N_REQ-1:0]  grant,
  output logic              S0,
  output logic              S1,
  output logic [DATA_W-1:0] Y,
  output logic              Y_valid,
  output logic              busy
);
  state_t            r_state;
  logic [N_REQ-1:0]  r_grant;
  logic [IDX_W-1:0]  r_sel;
  logic [IDX_W-1:0]  r_ptr;
  logic [DATA_W-1:0] r_y;
  logic              r_yv;

  logic [IDX_W-1:0]  w_pick;
  logic              w_any;
  logic              w_take;
  logic              w_release;
  logic [DATA_W-1:0] w_mux;

  // r_ptr always names the current owner while in GRANT, so one search serves every case
  rr_pick u_pick (.req(req), .ptr(r_ptr), .pick(w_pick), .any(w_any));

`ifdef MUX_ARB_TIMEOUT_EN
  logic [CNT_W-1:0]  r_hold;
  logic              w_others;
  assign w_others = |(req & ~onehot(r_ptr));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{HOLD_MAX[0], CNT_W[0]};
`endif

  always_comb begin
    w_take    = 1'b0;
    w_release = 1'b0;
    if (r_state == IDLE)
      w_take = w_any;
    else if (!req[r_ptr]) begin
      w_take    = w_any;
      w_release = !w_any;
    end
`ifdef MUX_ARB_TIMEOUT_EN
    else if (r_hold >= CNT_W'(HOLD_MAX - 1) && w_others)
      w_take = 1'b1;
`endif
  end

  always_comb begin
    case (r_sel)
      2'd0:    w_mux = A0;
      2'd1:    w_mux = A1;
      2'd2:    w_mux = A2;
      default: w_mux = A3;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_sel   <= '0;
      r_ptr   <= IDX_W'(N_REQ - 1);
      r_y     <= '0;
      r_yv    <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      r_hold  <= '0;
`endif
    end else begin
      r_yv <= |r_grant;
      if (|r_grant) r_y <= w_mux;
      if (w_take) begin
        r_state <= GRANT;
        r_grant <= onehot(w_pick);
        r_sel   <= w_pick;
        r_ptr   <= w_pick;
`ifdef MUX_ARB_TIMEOUT_EN
        r_hold  <= '0;
`endif
      end else if (w_release) begin
        r_state <= IDLE;
        r_grant <= '0;
      end
`ifdef MUX_ARB_TIMEOUT_EN
      else if (r_state == GRANT && r_hold != '1)
        r_hold <= r_hold + 1'b1;
`endif
    end
  end

  assign grant   = r_grant;
  assign S0      = r_sel[0];
  assign S1      = r_sel[1];
  assign Y       = r_y;
  assign Y_valid = r_yv;
  assign busy    = |r_grant;
endmodule
